moore_seq_pattern_tx: RTL and testbench

MOORE_SEQ_PATTERN_TX -- requirements
Module: moore_seq_pattern_tx

---
 rtl/seq_tx_pkg.sv | 27 ++
 rtl/seq_tx_shreg.sv | 41 ++++
 rtl/moore_seq_pattern_tx.sv | 154 +++++++++++++++
 tb/tb_moore_seq_pattern_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial pattern transmitter.
package seq_tx_pkg;

    // FSM state encoding shared by the transmitter and anything observing dbg_state
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        GAP   = 2'd2,
        DONE  = 2'd3
    } seq_tx_state_e;

    // Built-in pattern: 10110, sent MSB first
    localparam logic [3:0] DEF_LEN   = 4'd5;
    localparam logic [4:0] PAT_10110 = 5'b10110;

    // Effective pattern length: 0 means one bit, anything wider than the register is clipped
    function automatic logic [3:0] clamp_len(input logic [3:0] len, input logic [3:0] max_len);
        if (len == 4'd0) begin
            return 4'd1;
        end else if (len > max_len) begin
            return max_len;
        end else begin
            return len;
        end
    endfunction

endpackage

// File: rtl/seq_tx_shreg.sv
// Loadable MSB-first shift register. On load the pattern is left-aligned so
// that bit len-1 sits at the serial output; each shift presents the next lower bit.
module seq_tx_shreg #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         shift,
    input  logic [3:0]   len,
    input  logic [W-1:0] din,
    output logic         sout
);

    localparam logic [3:0] W_L = 4'(W);

    logic [W-1:0] sr_q;
    logic [W-1:0] sr_d;

    // Load has priority over shift; len is already within 1..W
    always_comb begin
        sr_d = sr_q;
        if (load) begin
            sr_d = din << (W_L - len);
        end else if (shift) begin
            sr_d = sr_q << 1;
        end
    end

    // Shift register storage, cleared by reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q <= '0;
        end else begin
            sr_q <= sr_d;
        end
    end

    assign sout = sr_q[W-1];

endmodule

// File: rtl/moore_seq_pattern_tx.sv
// Moore-FSM serial pattern transmitter: sends a latched pattern MSB first,
// repeated rep_cnt times, then pulses done for one cycle.
// Optional macro SEQ_TX_GAP_EN inserts one idle GAP cycle between copies.
//
// Handshake: start is a request sampled only in IDLE; there is no backpressure.
// out_valid=1 marks every cycle in which out_seq carries a pattern bit.
module moore_seq_pattern_tx
    import seq_tx_pkg::*;
#(
    parameter int               PAT_W   = 8,
    parameter logic [PAT_W-1:0] DEF_PAT = PAT_W'({3'b000, PAT_10110})
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             use_def,
    input  logic [PAT_W-1:0] pat_in,
    input  logic [3:0]       pat_len,
    input  logic [3:0]       rep_cnt,
    output logic             out_seq,
    output logic             out_valid,
    output logic             busy,
    output logic             done,
    output logic [1:0]       dbg_state
);

    localparam logic [3:0] PAT_W_L = 4'(PAT_W);
    localparam logic [1:0] S_IDLE  = IDLE;
    localparam logic [1:0] S_SHIFT = SHIFT;
`ifdef SEQ_TX_GAP_EN
    localparam logic [1:0] S_GAP   = GAP;
`endif
    localparam logic [1:0] S_DONE  = DONE;

    logic [1:0]       state_q, state_d;
    logic [PAT_W-1:0] pat_q, pat_d;
    logic [3:0]       len_q, len_d;
    logic [3:0]       bit_q, bit_d;
    logic [3:0]       copy_q, copy_d;

    logic [PAT_W-1:0] req_pat;
    logic [3:0]       req_len;
    logic [3:0]       req_rep;

    logic             sh_load;
    logic             sh_shift;
    logic [PAT_W-1:0] sh_din;
    logic [3:0]       sh_len;
    logic             sh_sout;

    // Resolve the requested pattern, length and repeat count from the inputs
    always_comb begin
        req_pat = use_def ? DEF_PAT : pat_in;
        req_len = clamp_len(use_def ? DEF_LEN : pat_len, PAT_W_L);
        req_rep = (rep_cnt == 4'd0) ? 4'd1 : rep_cnt;
    end

    // Next-state logic; both counters hold at zero and only ever count down
    always_comb begin
        state_d  = state_q;
        pat_d    = pat_q;
        len_d    = len_q;
        bit_d    = bit_q;
        copy_d   = copy_q;
        sh_load  = 1'b0;
        sh_shift = 1'b0;
        sh_din   = pat_q;
        sh_len   = len_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    pat_d    = req_pat;
                    len_d    = req_len;
                    bit_d    = req_len - 4'd1;
                    copy_d   = req_rep - 4'd1;
                    sh_load  = 1'b1;
                    sh_din   = req_pat;
                    sh_len   = req_len;
                    state_d  = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (bit_q != 4'd0) begin
                    bit_d    = bit_q - 4'd1;
                    sh_shift = 1'b1;
                end else if (copy_q != 4'd0) begin
                    copy_d   = copy_q - 4'd1;
`ifdef SEQ_TX_GAP_EN
                    state_d  = S_GAP;
`else
                    sh_load  = 1'b1;
                    bit_d    = len_q - 4'd1;
`endif
                end else begin
                    state_d  = S_DONE;
                end
            end
`ifdef SEQ_TX_GAP_EN
            S_GAP: begin
                sh_load = 1'b1;
                bit_d   = len_q - 4'd1;
                state_d = S_SHIFT;
            end
`endif
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and transfer registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
            pat_q   <= '0;
            len_q   <= '0;
            bit_q   <= '0;
            copy_q  <= '0;
        end else begin
            state_q <= state_d;
            pat_q   <= pat_d;
            len_q   <= len_d;
            bit_q   <= bit_d;
            copy_q  <= copy_d;
        end
    end

    seq_tx_shreg #(
        .W (PAT_W)
    ) u_shreg (
        .clk   (clk),
        .rst   (rst),
        .load  (sh_load),
        .shift (sh_shift),
        .len   (sh_len),
        .din   (sh_din),
        .sout  (sh_sout)
    );

    // Outputs decode from the state register and the registered shift output only
    assign out_valid = (state_q == S_SHIFT);
    assign out_seq   = out_valid & sh_sout;
    assign done      = (state_q == S_DONE);
`ifdef SEQ_TX_GAP_EN
    assign busy      = (state_q == S_SHIFT) || (state_q == S_GAP);
`else
    assign busy      = (state_q == S_SHIFT);
`endif
    assign dbg_state = state_q;

endmodule

// File: tb/tb_moore_seq_pattern_tx.sv
// Testbench for moore_seq_pattern_tx: randomized transfers against a bit-list model.
module tb_moore_seq_pattern_tx;

    localparam int         PAT_W = 8;
    localparam logic [7:0] DEF   = 8'b0001_0110;
`ifdef SEQ_TX_GAP_EN
    localparam int         GAP_CYC = 1;
`else
    localparam int         GAP_CYC = 0;
`endif

    logic       clk;
    logic       rst;
    logic       start;
    logic       use_def;
    logic [7:0] pat_in;
    logic [3:0] pat_len;
    logic [3:0] rep_cnt;
    logic       out_seq;
    logic       out_valid;
    logic       busy;
    logic       done;
    logic [1:0] dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    logic [0:0] exp_q[$];
    int         dur_q[$];

    moore_seq_pattern_tx #(
        .PAT_W (PAT_W)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .use_def   (use_def),
        .pat_in    (pat_in),
        .pat_len   (pat_len),
        .rep_cnt   (rep_cnt),
        .out_seq   (out_seq),
        .out_valid (out_valid),
        .busy      (busy),
        .done      (done),
        .dbg_state (dbg_state)
    );

    // Clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Reference model: the bit list a transfer must produce, and its busy length
    task automatic expect_xfer(input logic ud, input logic [7:0] p, input int l, input int r);
        logic [7:0] pp;
        int len;
        int reps;
        if (ud) begin
            pp  = DEF;
            len = 5;
        end else begin
            pp  = p;
            len = (l == 0) ? 1 : ((l > PAT_W) ? PAT_W : l);
        end
        reps = (r == 0) ? 1 : r;
        for (int c = 0; c < reps; c++) begin
            for (int i = len - 1; i >= 0; i--) begin
                exp_q.push_back(pp[i]);
            end
        end
        dur_q.push_back(len * reps + GAP_CYC * (reps - 1));
    endtask

    // Driver: one transfer; optional start re-pulse or reset at cycle k after the first bit
    task automatic send(input logic ud, input logic [7:0] p, input logic [3:0] l,
                        input logic [3:0] r, input int repulse_at, input int rst_at);
        bit got;
        got = 0;
        @(negedge clk);
        use_def = ud;
        pat_in  = p;
        pat_len = l;
        rep_cnt = r;
        start   = 1'b1;
        expect_xfer(ud, p, int'(l), int'(r));
        @(posedge clk);
        #1;
        start   = 1'b0;
        use_def = 1'($urandom_range(0, 1));
        pat_in  = 8'($urandom);
        pat_len = 4'($urandom);
        rep_cnt = 4'($urandom);
        @(negedge clk);
        check("first_bit_latency", {30'd0, out_valid, busy}, 32'd3);
        for (int k = 0; k < 400; k++) begin
            if (done) begin
                got = 1;
                break;
            end
            start = (k == repulse_at) ? 1'b1 : 1'b0;
            if (k == rst_at) begin
                #3;
                rst = 1'b0;
                #1;
                check("mid_reset_outputs", {27'd0, out_seq, out_valid, busy, done, dbg_state},
                      {27'd0, 4'b0000, seq_tx_pkg::IDLE});
                exp_q.delete();
                dur_q.delete();
                @(negedge clk);
                check("held_reset_outputs", {28'd0, out_seq, out_valid, busy, done}, 32'd0);
                #2;
                rst = 1'b1;
                return;
            end
            @(negedge clk);
        end
        start = 1'b0;
        check("done_seen", {31'd0, got}, 32'd1);
        @(negedge clk);
        check("idle_after_done", {29'd0, busy, done, out_valid}, 32'd0);
    endtask

    // Monitor / scoreboard: pops expected bits on out_valid, checks duration on done
    always @(negedge clk) begin
        if (rst !== 1'b1) begin
            cyc = 0;
        end else begin
            if (busy) cyc++;
            if (out_valid) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_bit: got %0b expected no bit", out_seq);
                end else begin
                    check("out_seq", {31'd0, out_seq}, {31'd0, exp_q.pop_front()});
                end
                check("busy_with_valid", {31'd0, busy}, 32'd1);
            end else begin
                check("seq_zero_when_invalid", {31'd0, out_seq}, 32'd0);
            end
            if (done) begin
                check("done_outputs", {30'd0, out_valid, busy}, 32'd0);
                if (dur_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done: got done expected none");
                end else begin
                    check("busy_duration", cyc, dur_q.pop_front());
                end
                check("bits_left_at_done", exp_q.size(), 32'd0);
                cyc = 0;
            end
        end
    end

    // Stimulus
    initial begin
        rst     = 1'b0;
        start   = 1'b1;
        use_def = 1'b1;
        pat_in  = 8'd0;
        pat_len = 4'd0;
        rep_cnt = 4'd0;
        #3;
        for (int t = 0; t < 3; t++) begin
            check("reset_outputs", {26'd0, out_seq, out_valid, busy, done, dbg_state},
                  {26'd0, 4'b0000, seq_tx_pkg::IDLE});
            #4;
        end
        #1;
        rst   = 1'b1;
        start = 1'b0;

        send(1'b1, 8'hFF, 4'd3, 4'd1, -1, -1);
        send(1'b1, 8'h00, 4'd7, 4'd3, -1, -1);
        send(1'b0, 8'hA5, 4'd8, 4'd1, -1, -1);
        send(1'b0, 8'hA5, 4'd12, 4'd1, -1, -1);
        send(1'b0, 8'hA5, 4'd0, 4'd1, -1, -1);
        send(1'b0, 8'h5A, 4'd4, 4'd0, -1, -1);
        send(1'b1, 8'h00, 4'd0, 4'd1, 2, -1);
        send(1'b0, 8'hA5, 4'd8, 4'd2, -1, 4);
        send(1'b0, 8'hA5, 4'd8, 4'd1, -1, -1);
        for (int n = 0; n < 20; n++) begin
            send(($urandom_range(0, 3) == 0) ? 1'b1 : 1'b0, 8'($urandom),
                 4'($urandom_range(0, 15)), 4'($urandom_range(0, 4)), -1, -1);
        end

        @(negedge clk);
        check("queues_empty", exp_q.size() + dur_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Watchdog
    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
